// File: rtl/imem_fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, buffers one instruction for decode.
// Optional IMEM_FETCH_WRAP_EN: loop back to RESET_PC after the last word.
module imem_fetch_sequencer #(
   parameter int PROG_LEN = 6,
   parameter int RESET_PC = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       halt_req,
   input  logic       branch_taken,
   input  logic [7:0] branch_target,
   output logic [7:0] instruction_address,
   input  logic [7:0] instruction_data,
   output logic       fetch_valid,
   input  logic       fetch_ready,
   output logic [7:0] fetch_instruction,
   output logic [7:0] fetch_pc,
   output logic       running,
   output logic       fetch_error
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_DRAIN,
      S_HALTED
   } state_t;

   localparam logic [7:0] LAST_PC = 8'(PROG_LEN - 1);
   localparam logic [7:0] RST_PC  = 8'(RESET_PC);
   localparam logic [8:0] LEN9    = 9'(PROG_LEN);

   state_t     state_q, state_d;
   logic [7:0] pc_q, pc_d;
   logic       valid_q, valid_d;
   logic [7:0] instr_q, instr_d;
   logic [7:0] fpc_q, fpc_d;
   logic       err_q, err_d;
   logic       run_q, run_d;

   logic accept;
   logic slot_free;
   logic tgt_bad;

   assign accept    = valid_q && fetch_ready;
   assign slot_free = !valid_q || fetch_ready;
   assign tgt_bad   = {1'b0, branch_target} >= LEN9;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      instr_d = instr_q;
      fpc_d   = fpc_q;
      err_d   = err_q;
      unique case (state_q)
         S_IDLE: begin
            valid_d = 1'b0;
            if (start) begin
               pc_d    = RST_PC;
               err_d   = 1'b0;
               state_d = S_FETCH;
            end
         end
         S_FETCH, S_DRAIN: begin
            if (branch_taken) begin
               // Redirect always flushes the buffered slot, accepted or not.
               valid_d = 1'b0;
               if (tgt_bad) begin
                  err_d   = 1'b1;
                  state_d = S_HALTED;
               end else begin
                  pc_d    = branch_target;
                  state_d = S_FETCH;
               end
            end else if (state_q == S_DRAIN) begin
               if (!valid_q || accept) begin
                  valid_d = 1'b0;
                  state_d = S_HALTED;
               end
            end else if (halt_req) begin
               if (accept) valid_d = 1'b0;
               state_d = S_DRAIN;
            end else if (slot_free) begin
               instr_d = instruction_data;
               fpc_d   = pc_q;
               valid_d = 1'b1;
               if (pc_q == LAST_PC) begin
`ifdef IMEM_FETCH_WRAP_EN
                  pc_d = RST_PC;
`else
                  state_d = S_DRAIN;
`endif
               end else begin
                  pc_d = pc_q + 8'd1;
               end
            end
         end
         S_HALTED: begin
            valid_d = 1'b0;
            if (start) begin
               pc_d    = RST_PC;
               err_d   = 1'b0;
               state_d = S_FETCH;
            end
         end
         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
         end
      endcase
      run_d = (state_d == S_FETCH) || (state_d == S_DRAIN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         pc_q    <= RST_PC;
         valid_q <= 1'b0;
         instr_q <= 8'h00;
         fpc_q   <= 8'h00;
         err_q   <= 1'b0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
         instr_q <= instr_d;
         fpc_q   <= fpc_d;
         err_q   <= err_d;
         run_q   <= run_d;
      end
   end

   assign instruction_address = pc_q;
   assign fetch_valid         = valid_q;
   assign fetch_instruction   = instr_q;
   assign fetch_pc            = fpc_q;
   assign running             = run_q;
   assign fetch_error         = err_q;

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Scoreboard bench for imem_fetch_sequencer: expected (pc, instr) pairs are
// queued when stimulus is driven and popped on each decode accept.
module tb_imem_fetch_sequencer;

   logic       clk;
   logic       rst;
   logic       start;
   logic       halt_req;
   logic       branch_taken;
   logic [7:0] branch_target;
   logic [7:0] instruction_address;
   logic [7:0] instruction_data;
   logic       fetch_valid;
   logic       fetch_ready;
   logic [7:0] fetch_instruction;
   logic [7:0] fetch_pc;
   logic       running;
   logic       fetch_error;

   typedef struct {
      logic [7:0] pc;
      logic [7:0] ins;
   } exp_t;

   exp_t sb[$];
   int   checks;
   int   failures;

   imem_fetch_sequencer #(.PROG_LEN(6), .RESET_PC(0)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .start               (start),
      .halt_req            (halt_req),
      .branch_taken        (branch_taken),
      .branch_target       (branch_target),
      .instruction_address (instruction_address),
      .instruction_data    (instruction_data),
      .fetch_valid         (fetch_valid),
      .fetch_ready         (fetch_ready),
      .fetch_instruction   (fetch_instruction),
      .fetch_pc            (fetch_pc),
      .running             (running),
      .fetch_error         (fetch_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] mem_rd(input logic [7:0] a);
      case (a)
         8'd0:    return 8'h11;
         8'd1:    return 8'h22;
         8'd2:    return 8'h33;
         8'd3:    return 8'h44;
         8'd4:    return 8'h55;
         8'd5:    return 8'h66;
         default: return 8'h00;
      endcase
   endfunction

   assign instruction_data = mem_rd(instruction_address);

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic push_exp(input logic [7:0] pc);
      exp_t e;
      e.pc  = pc;
      e.ins = mem_rd(pc);
      sb.push_back(e);
   endtask

   // Called just after a negedge with inputs set; an accept that is not
   // flushed by a branch is compared before the coming rising edge.
   task automatic tick();
      exp_t e;
      if (fetch_valid && fetch_ready && !branch_taken) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_accept", 32'(sb.size()), 32'd1);
         end else begin
            e = sb.pop_front();
            chk("acc_pc", 32'(fetch_pc), 32'(e.pc));
            chk("acc_instr", 32'(fetch_instruction), 32'(e.ins));
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (sb.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      chk("drain_left", 32'(sb.size()), 32'd0);
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      start         = 1'b0;
      halt_req      = 1'b0;
      branch_taken  = 1'b0;
      branch_target = 8'h00;
      fetch_ready   = 1'b0;
      sb.delete();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      do_reset();
      rst = 1'b1;
      #1;
      chk("rst_valid", 32'(fetch_valid), 32'd0);
      chk("rst_addr", 32'(instruction_address), 32'd0);
      chk("rst_instr", 32'(fetch_instruction), 32'd0);
      chk("rst_fpc", 32'(fetch_pc), 32'd0);
      chk("rst_running", 32'(running), 32'd0);
      chk("rst_err", 32'(fetch_error), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Full program at full throughput
      do_start();
      chk("start_running", 32'(running), 32'd1);
      chk("start_valid", 32'(fetch_valid), 32'd0);
      fetch_ready = 1'b1;
      for (int i = 0; i < 6; i++) push_exp(8'(i));
`ifdef IMEM_FETCH_WRAP_EN
      push_exp(8'd0);
      drain(20);
      chk("wrap_running", 32'(running), 32'd1);
`else
      drain(20);
      chk("end_valid", 32'(fetch_valid), 32'd0);
      chk("end_running", 32'(running), 32'd0);
      chk("end_addr", 32'(instruction_address), 32'd5);
      tick();
      chk("end_valid2", 32'(fetch_valid), 32'd0);
`endif

      // Back-pressure
      do_reset();
      do_start();
      tick();
      for (int i = 0; i < 3; i++) begin
         chk("bp_valid", 32'(fetch_valid), 32'd1);
         chk("bp_instr", 32'(fetch_instruction), 32'h11);
         chk("bp_fpc", 32'(fetch_pc), 32'd0);
         chk("bp_addr", 32'(instruction_address), 32'd1);
         tick();
      end
      fetch_ready = 1'b1;
      push_exp(8'd0);
      push_exp(8'd1);
      tick();
      chk("bp_rel_instr", 32'(fetch_instruction), 32'h22);
      chk("bp_rel_fpc", 32'(fetch_pc), 32'd1);
      drain(4);

      // Branch to 4 while pc 1 is buffered
      do_reset();
      do_start();
      fetch_ready = 1'b1;
      push_exp(8'd0);
      tick();
      tick();
      chk("br_pre_fpc", 32'(fetch_pc), 32'd1);
      branch_taken  = 1'b1;
      branch_target = 8'd4;
      tick();
      branch_taken = 1'b0;
      chk("br_bubble", 32'(fetch_valid), 32'd0);
      chk("br_addr", 32'(instruction_address), 32'd4);
      push_exp(8'd4);
      tick();
      chk("br_valid", 32'(fetch_valid), 32'd1);
      chk("br_fpc", 32'(fetch_pc), 32'd4);
      chk("br_instr", 32'(fetch_instruction), 32'h55);
      drain(3);

      // Out-of-range branch target
      do_reset();
      do_start();
      tick();
      branch_taken  = 1'b1;
      branch_target = 8'd9;
      tick();
      branch_taken = 1'b0;
      chk("bad_err", 32'(fetch_error), 32'd1);
      chk("bad_valid", 32'(fetch_valid), 32'd0);
      chk("bad_running", 32'(running), 32'd0);
      chk("bad_addr", 32'(instruction_address), 32'd1);
      fetch_ready = 1'b1;
      tick();
      tick();
      chk("bad_hold_valid", 32'(fetch_valid), 32'd0);
      chk("bad_hold_err", 32'(fetch_error), 32'd1);
      do_start();
      chk("restart_err", 32'(fetch_error), 32'd0);
      chk("restart_addr", 32'(instruction_address), 32'd0);
      push_exp(8'd0);
      drain(4);

      // Halt while a held instruction is buffered
      do_reset();
      do_start();
      tick();
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      chk("drain_running", 32'(running), 32'd1);
      tick();
      tick();
      chk("drain_valid", 32'(fetch_valid), 32'd1);
      chk("drain_fpc", 32'(fetch_pc), 32'd0);
      fetch_ready = 1'b1;
      push_exp(8'd0);
      tick();
      chk("halt_left", 32'(sb.size()), 32'd0);
      chk("halt_valid", 32'(fetch_valid), 32'd0);
      chk("halt_running", 32'(running), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("halt_stay", 32'(fetch_valid), 32'd0);
      end

      // Asynchronous reset mid-stream
      do_reset();
      do_start();
      fetch_ready = 1'b1;
      push_exp(8'd0);
      tick();
      tick();
      chk("ar_pre_valid", 32'(fetch_valid), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_valid", 32'(fetch_valid), 32'd0);
      chk("ar_addr", 32'(instruction_address), 32'd0);
      chk("ar_fpc", 32'(fetch_pc), 32'd0);
      chk("ar_instr", 32'(fetch_instruction), 32'd0);
      chk("ar_running", 32'(running), 32'd0);
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      do_start();
      push_exp(8'd0);
      push_exp(8'd1);
      drain(6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
